// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types and constants for the ALU issue queue: request
//               and response structs, operation-select encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int ALU_DWIDTH = 32;

  typedef logic [2:0] opsel_t;

  localparam opsel_t ALU_ADD = 3'd0;
  localparam opsel_t ALU_SUB = 3'd1;
  localparam opsel_t ALU_AND = 3'd2;
  localparam opsel_t ALU_OR  = 3'd3;
  localparam opsel_t ALU_XOR = 3'd4;
  localparam opsel_t ALU_NOT = 3'd5;
  localparam opsel_t ALU_SHL = 3'd6;
  localparam opsel_t ALU_SHR = 3'd7;

  typedef struct packed {
    logic [ALU_DWIDTH-1:0] op1;
    logic [ALU_DWIDTH-1:0] op2;
    opsel_t                opsel;
    logic                  mode;
  } alu_req_t;

  typedef struct packed {
    logic [ALU_DWIDTH-1:0] result;
    logic                  c;
    logic                  z;
    logic                  o;
    logic                  s;
  } alu_rsp_t;

endpackage
`default_nettype wire

// File: rtl/alu_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_req_fifo
// Description : DEPTH-entry circular FIFO of ALU requests with occupancy
//               count and full/empty status. Head entry is always visible.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_req_fifo
  import alu_pkg::*;
#(
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = ADDR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  alu_req_t         wdata,
  input  logic             pop,
  output alu_req_t         rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  alu_req_t          mem_q [DEPTH];
  alu_req_t          mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Next-state for storage, pointers (wrap naturally, DEPTH is a power of 2) and count
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards every queued request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_queue
// Description : Issue stage in front of the 32-bit ALU. Buffers requests in a
//               FIFO, presents the head entry to the ALU and captures the
//               result/flags into a valid/ready output register.
//               Optional macro ALU_Q_BYPASS_EN: a request arriving at an
//               empty queue with a free output register skips the FIFO and
//               is captured on the same edge it is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter  int DWIDTH = ALU_DWIDTH,  // must equal ALU_DWIDTH (struct width)
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_op1,
  input  logic [DWIDTH-1:0] in_op2,
  input  logic [2:0]        in_opsel,
  input  logic              in_mode,
  output logic [DWIDTH-1:0] alu_op1,
  output logic [DWIDTH-1:0] alu_op2,
  output logic [2:0]        alu_opsel,
  output logic              alu_mode,
  input  logic [DWIDTH-1:0] alu_result,
  input  logic              alu_c,
  input  logic              alu_z,
  input  logic              alu_o,
  input  logic              alu_s,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_result,
  output logic              out_c,
  output logic              out_z,
  output logic              out_o,
  output logic              out_s,
  output logic [CNT_W-1:0]  count
);

  localparam logic [0:0] OUT_EMPTY = 1'b0;
  localparam logic [0:0] OUT_FULL  = 1'b1;

  alu_req_t   in_req, head_req, issue_req;
  logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic       out_free, bypass, capture;
  logic [0:0] state_q, state_d;
  alu_rsp_t   rsp_q, rsp_d;

  assign in_req = '{op1: in_op1, op2: in_op2, opsel: in_opsel, mode: in_mode};

  // in_ready depends only on the FIFO, never on out_ready
  assign in_ready = !fifo_full;
  // Output register can take a new response this edge (empty, or draining)
  assign out_free = (state_q == OUT_EMPTY) || out_ready;

`ifdef ALU_Q_BYPASS_EN
  assign bypass = fifo_empty && in_valid && out_free;
`else
  assign bypass = 1'b0;
`endif

  assign capture   = out_free && (!fifo_empty || bypass);
  assign fifo_pop  = out_free && !fifo_empty;
  assign fifo_push = in_valid && !fifo_full && !bypass;

  alu_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (in_req),
    .pop   (fifo_pop),
    .rdata (head_req),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ALU operand mux: FIFO head, else the bypassed request, else zeros
  always_comb begin
    issue_req = '0;
    if (!fifo_empty) begin
      issue_req = head_req;
    end else if (bypass) begin
      issue_req = in_req;
    end
  end

  assign alu_op1   = issue_req.op1;
  assign alu_op2   = issue_req.op2;
  assign alu_opsel = issue_req.opsel;
  assign alu_mode  = issue_req.mode;

  // Output FSM: capture loads the ALU response; an accepted response with nothing new empties it
  always_comb begin
    state_d = state_q;
    rsp_d   = rsp_q;
    if (capture) begin
      state_d = OUT_FULL;
      rsp_d   = '{result: alu_result, c: alu_c, z: alu_z, o: alu_o, s: alu_s};
    end else if ((state_q == OUT_FULL) && out_ready) begin
      state_d = OUT_EMPTY;
    end
  end

  // Output register; reset drops any captured response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OUT_EMPTY;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
    end
  end

  assign out_valid  = (state_q == OUT_FULL);
  assign out_result = rsp_q.result;
  assign out_c      = rsp_q.c;
  assign out_z      = rsp_q.z;
  assign out_o      = rsp_q.o;
  assign out_s      = rsp_q.s;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_queue
// Description : Self-checking bench for alu_issue_queue with a behavioural
//               stand-in ALU and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_queue;
  import alu_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef ALU_Q_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready, in_mode, alu_mode;
  logic [DW-1:0] in_op1, in_op2, alu_op1, alu_op2, alu_result, out_result;
  logic [2:0]    in_opsel, alu_opsel;
  logic          alu_c, alu_z, alu_o, alu_s;
  logic          out_valid, out_ready, out_c, out_z, out_o, out_s;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  alu_issue_queue #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(in_op1), .in_op2(in_op2), .in_opsel(in_opsel), .in_mode(in_mode),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opsel(alu_opsel), .alu_mode(alu_mode),
    .alu_result(alu_result), .alu_c(alu_c), .alu_z(alu_z), .alu_o(alu_o), .alu_s(alu_s),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_c(out_c), .out_z(out_z), .out_o(out_o), .out_s(out_s),
    .count(count)
  );

  // Golden ALU: mode acts as carry-in for ADD (borrow-in for SUB)
  function automatic alu_rsp_t alu_f(input alu_req_t r);
    logic [DW:0]   wide;
    logic [DW-1:0] b;
    logic          cin;
    alu_rsp_t      x;
    x = '0;
    case (r.opsel)
      ALU_ADD, ALU_SUB: begin
        b    = (r.opsel == ALU_SUB) ? ~r.op2 : r.op2;
        cin  = (r.opsel == ALU_SUB) ? ~r.mode : r.mode;
        wide = {1'b0, r.op1} + {1'b0, b} + {{DW{1'b0}}, cin};
        x.result = wide[DW-1:0];
        x.c      = wide[DW];
        x.o      = (r.op1[DW-1] == b[DW-1]) && (x.result[DW-1] != r.op1[DW-1]);
      end
      ALU_AND: x.result = r.op1 & r.op2;
      ALU_OR:  x.result = r.op1 | r.op2;
      ALU_XOR: x.result = r.op1 ^ r.op2;
      ALU_NOT: x.result = ~r.op1;
      ALU_SHL: x.result = r.op1 << r.op2[4:0];
      default: x.result = r.op1 >> r.op2[4:0];
    endcase
    x.z = (x.result == '0);
    x.s = x.result[DW-1];
    return x;
  endfunction

  // Stand-in ALU driven by the DUT's operand ports
  alu_req_t alu_bus, in_bus;
  alu_rsp_t alu_out, out_bus;
  assign alu_bus    = '{op1: alu_op1, op2: alu_op2, opsel: alu_opsel, mode: alu_mode};
  assign alu_out    = alu_f(alu_bus);
  assign alu_result = alu_out.result;
  assign alu_c      = alu_out.c;
  assign alu_z      = alu_out.z;
  assign alu_o      = alu_out.o;
  assign alu_s      = alu_out.s;
  assign in_bus     = '{op1: in_op1, op2: in_op2, opsel: in_opsel, mode: in_mode};
  assign out_bus    = '{result: out_result, c: out_c, z: out_z, o: out_o, s: out_s};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard and monitor
  alu_rsp_t sb_q[$];
  int       cyc = 0;
  int       n_rsp = 0;
  int       n_hold = 0;
  int       last_acc_cyc = 0;
  int       last_rsp_cyc = 0;
  logic     stall_prev = 1'b0;
  alu_rsp_t prev_out;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        n_hold++;
        check_eq("hold_stable", 64'(out_bus), 64'(prev_out));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("spurious_rsp", 64'(1), 64'(0));
        end else begin
          check_eq("rsp_order", 64'(out_bus), 64'(sb_q.pop_front()));
        end
        n_rsp++;
        last_rsp_cyc = cyc;
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(alu_f(in_bus));
        last_acc_cyc = cyc;
      end
      stall_prev = out_valid && !out_ready;
      prev_out   = out_bus;
    end else begin
      stall_prev = 1'b0;
    end
  end

  function automatic alu_req_t rand_req();
    alu_req_t r;
    r.op1   = $urandom;
    r.op2   = $urandom;
    r.opsel = opsel_t'($urandom_range(0, 7));
    r.mode  = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // Called just after a rising edge; holds the request until accepted
  task automatic drive_req(input alu_req_t r);
    logic done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_op1   = r.op1;
    in_op2   = r.op2;
    in_opsel = r.opsel;
    in_mode  = r.mode;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check_eq("req_accept_timeout", 64'(0), 64'(1));
  endtask

  // Waits for the scoreboard to empty, then realigns to just after a rising edge
  task automatic wait_drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !out_valid) done = 1'b1;
    end
    if (!done) check_eq("drain_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic single_op(input alu_req_t r, input string tag, input logic [DW-1:0] exp_res,
                           input logic [3:0] exp_czos);
    int lat;
    out_ready = 1'b1;
    drive_req(r);
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      if (out_valid) lat = i;
    end
    check_eq({tag, "_latency"}, 64'(lat), 64'(LAT));
    check_eq({tag, "_result"}, 64'(out_result), 64'(exp_res));
    check_eq({tag, "_flags_czos"}, 64'({out_c, out_z, out_o, out_s}), 64'(exp_czos));
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    alu_req_t r;
    int       base, first, nv;
    logic     t6_done;
    in_valid = 1'b0; in_op1 = '0; in_op2 = '0; in_opsel = '0; in_mode = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_out_valid", 64'(out_valid), 64'(0));
    check_eq("rst_count", 64'(count), 64'(0));
    check_eq("rst_in_ready", 64'(in_ready), 64'(1));
    check_eq("rst_out_bus", 64'(out_bus), 64'(0));
    check_eq("empty_alu_ops", 64'({alu_op1, alu_op2}), 64'(0));
    check_eq("empty_alu_sel", 64'({alu_opsel, alu_mode}), 64'(0));
    @(posedge clk);
    #1;

    // Reset in the middle of a three-request burst
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive_req(rand_req());
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 64'(out_valid), 64'(0));
    check_eq("midrst_count", 64'(count), 64'(0));
    check_eq("midrst_in_ready", 64'(in_ready), 64'(1));
    sb_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    check_eq("no_rsp_after_rst", 64'(nv), 64'(0));
    @(posedge clk);
    #1;

    // Carry out to zero, then signed overflow
    single_op('{op1: 32'hFFFF_FFFF, op2: 32'h1, opsel: ALU_ADD, mode: 1'b0},
              "add_carry", 32'h0, 4'b1100);
    single_op('{op1: 32'h7FFF_FFFF, op2: 32'h1, opsel: ALU_ADD, mode: 1'b0},
              "add_ovf", 32'h8000_0000, 4'b0011);

    // Backpressure: fill the queue behind a stalled output
    base = n_rsp;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive_req(rand_req());
    @(negedge clk);
    check_eq("full_count", 64'(count), 64'(DEPTH));
    check_eq("full_in_ready", 64'(in_ready), 64'(0));
    check_eq("full_out_valid", 64'(out_valid), 64'(1));
    @(posedge clk);
    #1;
    r = rand_req();
    in_valid = 1'b1; in_op1 = r.op1; in_op2 = r.op2; in_opsel = r.opsel; in_mode = r.mode;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("blocked_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drive_req(r);
    wait_drain();
    check_eq("backpressure_rsp_count", 64'(n_rsp - base), 64'(6));

    // Back-to-back stream: one response per cycle, pointers wrap several times
    base = n_rsp;
    out_ready = 1'b1;
    drive_req(rand_req());
    first = last_acc_cyc;
    for (int i = 1; i < 16; i++) drive_req(rand_req());
    wait_drain();
    check_eq("stream_rsp_count", 64'(n_rsp - base), 64'(16));
    check_eq("stream_span_cycles", 64'(last_rsp_cyc - first), 64'(15 + LAT));

    // Alternating out_ready with random ops
    base = n_rsp;
    t6_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) drive_req(rand_req());
        t6_done = 1'b1;
      end
      begin
        while (!t6_done) begin
          @(posedge clk);
          #1 out_ready = ~out_ready;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    check_eq("toggle_rsp_count", 64'(n_rsp - base), 64'(24));
    check_eq("toggle_saw_stalls", 64'(n_hold > 0), 64'(1));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
